coarse_delay_stage: RTL and testbench

- Programmable sample-granular delay line, placed directly upstream of fine_delay_stage in the pt_feedback chain.
- Stores samples in a circular buffer, advancing once per ce_i pulse (decimated sample strobe, typically one pulse every 8 clocks).
- Outputs the sample from delay_i strobes earlier, together with a 1-cycle ce_o that drives the fine stage's ce_i.
- Coarse (this block) plus fine (next stage) together give the total feedback delay.

---
 rtl/pt_feedback_pkg.sv | 17 +
 rtl/sdp_ram_sync.sv | 25 ++
 rtl/coarse_delay_stage.sv | 89 ++++++++
 tb/tb_coarse_delay_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pt_feedback_pkg.sv
// Shared types and constants for the pt_feedback sample chain.
package pt_feedback_pkg;

  localparam int SAMPLE_WIDTH = 14;
  localparam int CE_DIVIDER   = 8;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  localparam sample_t SAMPLE_ZERO = '0;

  typedef enum logic [1:0] {
    SEL_ZERO   = 2'd0,
    SEL_BYPASS = 2'd1,
    SEL_RAM    = 2'd2
  } out_sel_e;

endpackage

// File: rtl/sdp_ram_sync.sv
// Simple dual-port RAM, one write port and one registered read-first read port.
module sdp_ram_sync #(
  parameter int WIDTH  = 14,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // Non-blocking write and read in one block: a same-address read returns old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/coarse_delay_stage.sv
// Sample-granular circular-buffer delay line feeding fine_delay_stage.
// Optional muting on delay change: define COARSE_DELAY_MUTE_ON_CHANGE_EN.
module coarse_delay_stage
  import pt_feedback_pkg::*;
#(
  parameter int WIDTH  = SAMPLE_WIDTH,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] delay_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic              ce_o,
  output logic [WIDTH-1:0]  data_o
);

  localparam logic [ADDR_W-1:0] FILL_MAX = '1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] delay_q;
  logic [ADDR_W-1:0] fill_eff;
  logic [ADDR_W-1:0] fill_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  ram_rd;
  logic [WIDTH-1:0]  byp_q;
  out_sel_e          sel_q;
  out_sel_e          sel_next;

  always_comb begin
    fill_eff = fill_cnt;
`ifdef COARSE_DELAY_MUTE_ON_CHANGE_EN
    // A new tap restarts priming so the output never splices two delays.
    if (delay_i != delay_q) fill_eff = '0;
`endif
    fill_next = (fill_eff == FILL_MAX) ? FILL_MAX : fill_eff + 1'b1;
    rd_addr   = wr_ptr - delay_i;
    if (delay_i == '0)
      sel_next = SEL_BYPASS;
    else if (fill_eff >= delay_i)
      sel_next = SEL_RAM;
    else
      sel_next = SEL_ZERO;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ce_o     <= 1'b0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      delay_q  <= '0;
      byp_q    <= '0;
      sel_q    <= SEL_ZERO;
    end else begin
      ce_o <= ce_i;
      if (ce_i) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fill_cnt <= fill_next;
        delay_q  <= delay_i;
        byp_q    <= data_i;
        sel_q    <= sel_next;
      end
    end
  end

  sdp_ram_sync #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (ce_i),
    .wr_addr (wr_ptr),
    .wr_data (data_i),
    .rd_en   (ce_i),
    .rd_addr (rd_addr),
    .rd_data (ram_rd)
  );

  // RAM read register has no reset; the select register masks it to zero.
  always_comb begin
    unique case (sel_q)
      SEL_BYPASS: data_o = byp_q;
      SEL_RAM:    data_o = ram_rd;
      default:    data_o = WIDTH'(SAMPLE_ZERO);
    endcase
  end

endmodule

// File: tb/tb_coarse_delay_stage.sv
// Randomized self-checking bench for coarse_delay_stage against a sample-history model.
module tb_coarse_delay_stage;
  import pt_feedback_pkg::*;

  localparam int WIDTH  = SAMPLE_WIDTH;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              ce_i = 1'b0;
  logic [ADDR_W-1:0] delay_i = '0;
  logic [WIDTH-1:0]  data_i = '0;
  logic              ce_o;
  logic [WIDTH-1:0]  data_o;

  int checks = 0;
  int errors = 0;

  // Model: every sample since reset, indexed by strobe number.
  int   hist[$];
  int   k;
  int   prime_start;
  int   dq;
  logic exp_ce;
  int   exp_data;

  always #5 clk_i = ~clk_i;

  coarse_delay_stage #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .ce_i    (ce_i),
    .delay_i (delay_i),
    .data_i  (data_i),
    .ce_o    (ce_o),
    .data_o  (data_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    k = 0;
    prime_start = 0;
    dq = 0;
    exp_ce = 1'b0;
    exp_data = 0;
  endtask

  function automatic int model_strobe(input int d, input int din);
    int val;
`ifdef COARSE_DELAY_MUTE_ON_CHANGE_EN
    if (d != dq) prime_start = k;
`endif
    if (d == 0)
      val = din;
    else if (k - prime_start >= d)
      val = hist[k - d];
    else
      val = 0;
    hist.push_back(din);
    k++;
    dq = d;
    return val;
  endfunction

  // One clock: check the previous edge's outputs, then drive this cycle.
  task automatic cycle(input logic ce, input int d, input int din);
    @(negedge clk_i);
    check("ce_o", int'(ce_o), int'(exp_ce));
    check("data_o", int'(data_o), exp_data);
    ce_i    = ce;
    delay_i = ADDR_W'(d);
    data_i  = WIDTH'(din);
    exp_ce  = ce;
    if (ce) exp_data = model_strobe(d, din & ((1 << WIDTH) - 1));
  endtask

  task automatic strobe_gap(input int d, input int din, input int gap);
    cycle(1'b1, d, din);
    for (int i = 0; i < gap; i++) cycle(1'b0, $urandom_range(DEPTH-1), $urandom);
  endtask

  initial begin
    int ramp;
    int d;
    model_reset();
    repeat (3) @(negedge clk_i);
    check("reset_ce_o", int'(ce_o), 0);
    check("reset_data_o", int'(data_o), 0);
    rst_ni = 1'b1;

    // Bypass at delay 0, one strobe per CE_DIVIDER clocks.
    for (int i = 0; i < 6; i++) strobe_gap(0, 100, CE_DIVIDER - 1);

    // Ramp at delay 3 on top of a fresh reset.
    @(negedge clk_i);
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    ramp = 1;
    for (int i = 0; i < 10; i++) strobe_gap(3, ramp++, CE_DIVIDER - 1);

    // Delay change 5 -> 2 mid-ramp.
    for (int i = 0; i < 8; i++) strobe_gap(5, ramp++, CE_DIVIDER - 1);
    for (int i = 0; i < 6; i++) strobe_gap(2, ramp++, CE_DIVIDER - 1);

    // ce_i held high for 16 clocks at delay 4.
    for (int i = 0; i < 16; i++) cycle(1'b1, 4, ramp++);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4, 0);

    // Maximum delay across more than two pointer wraps, back-to-back strobes.
    for (int i = 0; i < 2 * DEPTH + 40; i++) cycle(1'b1, DEPTH - 1, ramp++);
    cycle(1'b0, 0, 0);

    // Randomized delays, data and strobe spacing.
    d = $urandom_range(12);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(15) == 0) d = $urandom_range(12);
      if ($urandom_range(31) == 0) d = $urandom_range(DEPTH - 1);
      strobe_gap(d, $urandom, $urandom_range(CE_DIVIDER + 1));
    end

    // Asynchronous reset mid-stream, while ce_o is high.
    for (int i = 0; i < 6; i++) strobe_gap(3, ramp++, 2);
    cycle(1'b1, 3, ramp++);
    @(posedge clk_i);
    #1;
    ce_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("async_rst_ce_o", int'(ce_o), 0);
    check("async_rst_data_o", int'(data_o), 0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) strobe_gap(3, 500 + i, CE_DIVIDER - 1);

    @(negedge clk_i);
    check("final_ce_o", int'(ce_o), int'(exp_ce));
    check("final_data_o", int'(data_o), exp_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
